// File: rtl/fsm_read_arbiter.sv
// fsm_read_arbiter: round-robin arbiter that shares one read engine among
// NREQ requesters. A granted operation walks IDLE -> LAUNCH -> RUN -> DRAIN.
// RUN ends when the engine reports init again, or when the RUN cycle count
// reaches TIMEOUT. A timeout raises err together with done.
//
// Handshake: req is a level that the requester holds until it sees its done
// pulse. grant is the one-hot owner of the engine. done (and err, if the run
// timed out) pulse for exactly one cycle while the FSM is in DRAIN. Dropping
// req or changing path after the grant has no effect on the running operation.
module fsm_read_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] path,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            in1,
  output logic            in2,
  output logic            in3,
  input  logic            out1,
  input  logic            out2,
  output logic [NREQ-1:0] done,
  output logic            err,
  output logic [1:0]      state_dbg
);

  localparam int        IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] TMO    = 8'(TIMEOUT);
  localparam logic [7:0] TMO_M1 = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic            path_q, path_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            tmo_q, tmo_d;
  logic            in1_q, in1_d;
  logic            in2_q, in2_d;
  logic            in3_q, in3_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_q, err_d;

  logic            eng_init;
  logic            found;
  logic [IW-1:0]   win;

  assign eng_init = out1 & ~out2;

  // Round-robin pick: lowest asserted req at or above rr_q, else lowest overall.
  always_comb begin
    found = 1'b0;
    win   = rr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (IW'(i) >= rr_q)) begin
        found = 1'b1;
        win   = IW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        win   = IW'(i);
      end
    end
  end

  // Next-state logic plus the registered engine stimulus and completion pulses.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    path_d  = path_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (found && eng_init) begin
          state_d      = LAUNCH;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          idx_d        = win;
          path_d       = path[win];
        end
      end
      LAUNCH: begin
        state_d = RUN;
        cnt_d   = 8'd0;
        tmo_d   = 1'b0;
      end
      RUN: begin
        if (cnt_q < TMO) begin
          cnt_d = cnt_q + 8'd1;
        end
        if (eng_init) begin
          state_d = DRAIN;
        end else if (cnt_q >= TMO_M1) begin
          state_d = DRAIN;
          tmo_d   = 1'b1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        grant_d = '0;
        rr_d    = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    in1_d  = (state_d == LAUNCH);
    in2_d  = ((state_d == LAUNCH) || (state_d == RUN)) && path_d;
    in3_d  = (state_d == RUN) && !path_d;
    done_d = (state_d == DRAIN) ? grant_d : '0;
    err_d  = (state_d == DRAIN) && tmo_d;
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      rr_q    <= '0;
      path_q  <= 1'b0;
      cnt_q   <= 8'd0;
      tmo_q   <= 1'b0;
      in1_q   <= 1'b0;
      in2_q   <= 1'b0;
      in3_q   <= 1'b0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      path_q  <= path_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      in3_q   <= in3_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign in1       = in1_q;
  assign in2       = in2_q;
  assign in3       = in3_q;
  assign done      = done_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule
